// File: rtl/pc_sequencer.sv
// Program-counter stage: picks the next fetch address from trap, branch, jump or
// sequential sources, and holds a ranked pending redirect across fetch stalls.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0080),
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            trap_req,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_req,
  input  logic [XLEN-1:0] jmp_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            flush_if,
  output logic            flush_id,
  output logic            misalign_err,
  output logic            redirect_pend
);

  typedef enum logic [1:0] {RK_NONE, RK_JMP, RK_BR, RK_TRAP} rank_e;

  // ALIGN_BITS of 0 yields an all-zero mask, which disables the check.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [XLEN-1:0] pc_q, pc_d;
  rank_e           pend_rank_q, pend_rank_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_mis_q, pend_mis_d;
  logic            flush_if_q, flush_if_d;
  logic            flush_id_q, flush_id_d;
  logic            misalign_q, misalign_d;

  rank_e           req_rank, sel_rank;
  logic [XLEN-1:0] req_raw, req_tgt, sel_tgt;
  logic            req_mis, sel_mis, take_req;

  assign pc_plus = pc_q + XLEN'(INC);

  always_comb begin
    if (trap_req)      req_rank = RK_TRAP;
    else if (br_taken) req_rank = RK_BR;
    else if (jmp_req)  req_rank = RK_JMP;
    else               req_rank = RK_NONE;

    req_raw = br_taken ? br_target : jmp_target;
    req_mis = (req_rank == RK_BR || req_rank == RK_JMP) && ((req_raw & ALIGN_MASK) != '0);
    req_tgt = (req_rank == RK_TRAP || req_mis) ? TRAP_VECTOR : req_raw;

    // An empty pending slot has rank NONE, so any request outranks it.
    take_req = req_rank > pend_rank_q;
    sel_rank = take_req ? req_rank : pend_rank_q;
    sel_tgt  = take_req ? req_tgt  : pend_tgt_q;
    sel_mis  = take_req ? req_mis  : pend_mis_q;

    pc_d        = pc_q;
    pend_rank_d = pend_rank_q;
    pend_tgt_d  = pend_tgt_q;
    pend_mis_d  = pend_mis_q;
    flush_if_d  = 1'b0;
    flush_id_d  = 1'b0;
    misalign_d  = 1'b0;

    if (stall) begin
      if (take_req) begin
        pend_rank_d = req_rank;
        pend_tgt_d  = req_tgt;
        pend_mis_d  = req_mis;
      end
    end else begin
      pend_rank_d = RK_NONE;
      pend_tgt_d  = '0;
      pend_mis_d  = 1'b0;
      if (sel_rank != RK_NONE) begin
        pc_d       = sel_tgt;
        flush_if_d = 1'b1;
        // A misaligned jump is redirected like a trap, so it squashes ID/EX too.
        flush_id_d = (sel_rank != RK_JMP) || sel_mis;
        misalign_d = sel_mis;
      end else begin
        pc_d = pc_plus;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_VECTOR;
      pend_rank_q <= RK_NONE;
      pend_tgt_q  <= '0;
      pend_mis_q  <= 1'b0;
      flush_if_q  <= 1'b0;
      flush_id_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pend_rank_q <= pend_rank_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_mis_q  <= pend_mis_d;
      flush_if_q  <= flush_if_d;
      flush_id_q  <= flush_id_d;
      misalign_q  <= misalign_d;
    end
  end

  assign pc            = pc_q;
  assign flush_if      = flush_if_q;
  assign flush_id      = flush_id_q;
  assign misalign_err  = misalign_q;
  assign redirect_pend = (pend_rank_q != RK_NONE);

endmodule
